pcie_bas_write_arbiter: RTL and testbench
=========================================

# pcie_bas_write_arbiter

Shares the single 512-bit PCIe Avalon-MM burst-master (BAS) write port between two requesters: requester 0 is the fpga_to_cpu packet/descriptor DMA writer, requester 1 is a low-rate notification writer (e.g. TX completion or head write-back). It arbitrates round-robin at burst granularity, locks the port for the full length of an accepted burst, and keeps per-requester statistics. It sits between the writers and the `pcie_bas_*` top-level ports in `pcie_top`.

## Interface
Parameters:
- `NB_REQ`, 2, number of requesters (fixed at 2 for this revision).
- `MAX_BURST`, 8, largest legal burstcount on BAS.

Ports:
- `pcie_clk`  in  1  clock.
- `pcie_reset_n`  in  1  reset: synchronous, active-low.
- `sw_reset`  in  1  synchronous clear of the statistics counters only.
- `req_write[i]`  in  1  requester i write (Avalon-MM, i = 0..1).
- `req_address[i]`  in  64  burst start address, sampled on the first beat.
- `req_burstcount[i]`  in  4  beats in the burst, sampled on the first beat.
- `req_writedata[i]`  in  512  beat data.
- `req_byteenable[i]`  in  64  beat byte enables.
- `req_waitrequest[i]`  out  1  back-pressure to requester i.
- `pcie_bas_waitrequest`  in  1  back-pressure from the PCIe IP.
- `pcie_bas_write`  out  1.
- `pcie_bas_address`  out  64.
- `pcie_bas_burstcount`  out  4.
- `pcie_bas_writedata`  out  512.
- `pcie_bas_byteenable`  out  64.
- `req_burst_cnt[i]`  out  32  bursts completed by requester i.
- `req_beat_cnt[i]`  out  32  beats accepted from requester i.
- `bad_burst_cnt`  out  32  first beats with burstcount 0 or greater than `MAX_BURST`.

## Operation
- The data path is a combinational mux selected by `owner`. There is no data register.
- The non-owner always sees `req_waitrequest = 1`. The owner sees `req_waitrequest = pcie_bas_waitrequest`.
- `rr_ptr` is 1 bit and names the preferred requester. It resets to 0.
- Beat accept: `pcie_bas_write & !pcie_bas_waitrequest`.
- State IDLE:
  - If only one requester asserts write, it becomes `owner`.
  - If both assert write, `owner = rr_ptr`.
  - If neither asserts write, `pcie_bas_write = 0` and `owner` holds its last value.
  - On an accepted first beat with effective burstcount 1: stay in IDLE, toggle `rr_ptr` to the other requester, and count the burst.
  - On an accepted first beat with effective burstcount N > 1: go to BURST with `beats_left = N-1`.
  - On a stalled first beat: go to STALL.
- State STALL: `owner` is frozen, so a held request can never be re-granted to the other requester. It takes the same exits as IDLE on accept.
- State BURST: `owner` is frozen.
  - `beats_left` decrements on each accepted beat.
  - The owner may deassert write between beats. This is a bubble: `pcie_bas_write = 0` and the lock is kept.
  - When the last beat (`beats_left == 1`) is accepted: go to IDLE, toggle `rr_ptr`, and count the burst.
- Effective burstcount: 0 is treated as 1. Values above `MAX_BURST` are clipped to `MAX_BURST`. Both cases increment `bad_burst_cnt`. The raw value is still forwarded on `pcie_bas_burstcount`.
- Counters are 32-bit wrapping. They clear on reset or on `sw_reset`. While `sw_reset` is high, no counter increments.
- Requesters must not make `req_write` depend on `req_waitrequest`, as Avalon requires. This keeps the IDLE grant free of combinational loops.

## Timing
- Zero-cycle latency: a granted beat appears on the `pcie_bas_*` outputs in the same cycle it is presented.
- State, `owner`, `rr_ptr`, `beats_left` and the counters update on the `pcie_clk` edge after an accept.
- The next burst can be granted in the cycle immediately after a burst's last beat is accepted, so there is no dead cycle between bursts.
- Reset values while `pcie_reset_n = 0`:
  - `pcie_bas_write = 0`
  - `req_waitrequest[0] = req_waitrequest[1] = 1`
  - state IDLE, `owner = 0`, `rr_ptr = 0`, `beats_left = 0`
  - all counters 0
- Reset asserted mid-burst aborts the lock. The PCIe IP is reset together with this block.
- If `sw_reset` rises mid-burst, the lock and arbitration are unaffected.

## Test plan
- **Single requester, back-to-back:** req0 issues three bursts of 4 with `pcie_bas_waitrequest = 0`.
  - Expect 12 consecutive beats with no gaps.
  - Expect `req_burst_cnt[0] = 3`, `req_beat_cnt[0] = 12`, and req1 waitrequest high throughout.
- **Simultaneous contention from reset:** req0 and req1 each issue a burst of 2 in the same cycle.
  - Expect order req0 beats, then req1 beats, for 4 consecutive beats.
  - Expect `rr_ptr = 0` afterwards.
- **Stalled first beat:** req1 alone asserts write with burstcount 3 while `pcie_bas_waitrequest = 1` for 5 cycles. Req0 asserts write at cycle 2.
  - Expect the grant to stay with req1 through the stall and all 3 req1 beats to complete first.
  - Then expect req0 to be granted.
- **Bubble mid-burst:** req0 sends a burst of 4 and drops write for 2 cycles after beat 2, while req1 is requesting.
  - Expect req1 to stay waitrequested until req0's beat 4 is accepted.
  - Expect `pcie_bas_write = 0` during the bubble.
- **Illegal burstcount:** req0 sends burstcount 0, then burstcount 12.
  - Expect the 0 burst to be treated as 1 beat and the 12 burst to lock for 8 beats.
  - Expect `bad_burst_cnt = 2`.
- **Resets:** assert `pcie_reset_n = 0` during beat 3 of 8.
  - Expect all outputs at reset values on the next edge, and the next request after release to be granted from IDLE with `rr_ptr = 0`.
  - Pulse `sw_reset` separately and expect only the counters to clear.

Source files
------------

// File: rtl/pcie_bas_write_arbiter_if.sv
// Requester-side and PCIe BAS-side write bus seen by the BAS write arbiter.
// The master modport is the arbiter; the slave modport is the surrounding writers and PCIe IP.
interface pcie_bas_write_arbiter_if #(
  parameter int NB_REQ = 2
);
  logic [NB_REQ-1:0]        req_write;
  logic [NB_REQ-1:0][63:0]  req_address;
  logic [NB_REQ-1:0][3:0]   req_burstcount;
  logic [NB_REQ-1:0][511:0] req_writedata;
  logic [NB_REQ-1:0][63:0]  req_byteenable;
  logic [NB_REQ-1:0]        req_waitrequest;

  logic                     pcie_bas_waitrequest;
  logic                     pcie_bas_write;
  logic [63:0]              pcie_bas_address;
  logic [3:0]               pcie_bas_burstcount;
  logic [511:0]             pcie_bas_writedata;
  logic [63:0]              pcie_bas_byteenable;

  modport master (
    input  req_write, req_address, req_burstcount, req_writedata, req_byteenable,
    output req_waitrequest,
    input  pcie_bas_waitrequest,
    output pcie_bas_write, pcie_bas_address, pcie_bas_burstcount,
    output pcie_bas_writedata, pcie_bas_byteenable
  );

  modport slave (
    output req_write, req_address, req_burstcount, req_writedata, req_byteenable,
    input  req_waitrequest,
    output pcie_bas_waitrequest,
    input  pcie_bas_write, pcie_bas_address, pcie_bas_burstcount,
    input  pcie_bas_writedata, pcie_bas_byteenable
  );
endinterface

// File: rtl/pcie_bas_write_arbiter.sv
// Two-requester round-robin arbiter for the 512-bit PCIe BAS write port.
// Grants at burst granularity, holds the lock for a whole burst, and keeps per-requester statistics.
module pcie_bas_write_arbiter #(
  parameter int NB_REQ    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                     pcie_clk,
  input  logic                     pcie_reset_n,
  input  logic                     sw_reset,
  pcie_bas_write_arbiter_if.master bus,
  output logic [NB_REQ-1:0][31:0]  req_burst_cnt,
  output logic [NB_REQ-1:0][31:0]  req_beat_cnt,
  output logic [31:0]              bad_burst_cnt
);

  localparam logic [3:0] MAX_BC = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t     state_r, state_nxt_s;
  logic       owner_r, owner_nxt_s;
  logic       rr_ptr_r, rr_ptr_nxt_s;
  logic [3:0] beats_left_r, beats_left_nxt_s;

  logic       grant_s;
  logic [3:0] raw_bc_s;
  logic [3:0] eff_bc_s;
  logic       bad_bc_s;
  logic       accept_s;
  logic       first_acc_s;
  logic       burst_done_s;

  // Grant selection: free choice only in IDLE, otherwise the owner is locked
  always_comb begin
    grant_s = owner_r;
    if (state_r == IDLE) begin
      if (bus.req_write[0] && bus.req_write[1]) begin
        grant_s = rr_ptr_r;
      end else if (bus.req_write[1]) begin
        grant_s = 1'b1;
      end else if (bus.req_write[0]) begin
        grant_s = 1'b0;
      end else begin
        grant_s = owner_r;
      end
    end else begin
      grant_s = owner_r;
    end
  end

  // Zero-latency data mux and back-pressure fan-out
  always_comb begin
    bus.pcie_bas_write      = pcie_reset_n & bus.req_write[grant_s];
    bus.pcie_bas_address    = bus.req_address[grant_s];
    bus.pcie_bas_burstcount = bus.req_burstcount[grant_s];
    bus.pcie_bas_writedata  = bus.req_writedata[grant_s];
    bus.pcie_bas_byteenable = bus.req_byteenable[grant_s];
    bus.req_waitrequest[0]  = ~pcie_reset_n | grant_s | bus.pcie_bas_waitrequest;
    bus.req_waitrequest[1]  = ~pcie_reset_n | ~grant_s | bus.pcie_bas_waitrequest;
  end

  // Effective burst length: 0 acts as 1, oversize clips to MAX_BURST
  always_comb begin
    raw_bc_s = bus.req_burstcount[grant_s];
    accept_s = bus.pcie_bas_write & ~bus.pcie_bas_waitrequest;
    bad_bc_s = (raw_bc_s == 4'd0) || (raw_bc_s > MAX_BC);
    if (raw_bc_s == 4'd0) begin
      eff_bc_s = 4'd1;
    end else if (raw_bc_s > MAX_BC) begin
      eff_bc_s = MAX_BC;
    end else begin
      eff_bc_s = raw_bc_s;
    end
  end

  // Next-state logic for burst locking and round-robin pointer
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    rr_ptr_nxt_s     = rr_ptr_r;
    beats_left_nxt_s = beats_left_r;
    first_acc_s      = 1'b0;
    burst_done_s     = 1'b0;
    case (state_r)
      IDLE, STALL: begin
        owner_nxt_s = grant_s;
        if (accept_s) begin
          first_acc_s = 1'b1;
          if (eff_bc_s == 4'd1) begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = ~grant_s;
            burst_done_s = 1'b1;
          end else begin
            state_nxt_s      = BURST;
            beats_left_nxt_s = eff_bc_s - 4'd1;
          end
        end else if (bus.pcie_bas_write) begin
          state_nxt_s = STALL;
        end else begin
          state_nxt_s = state_r;
        end
      end
      BURST: begin
        if (accept_s) begin
          beats_left_nxt_s = beats_left_r - 4'd1;
          if (beats_left_r == 4'd1) begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = ~owner_r;
            burst_done_s = 1'b1;
          end else begin
            state_nxt_s = BURST;
          end
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: begin
        state_nxt_s      = IDLE;
        beats_left_nxt_s = 4'd0;
      end
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge pcie_clk) begin
    if (!pcie_reset_n) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      rr_ptr_r     <= 1'b0;
      beats_left_r <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      rr_ptr_r     <= rr_ptr_nxt_s;
      beats_left_r <= beats_left_nxt_s;
    end
  end

  // Statistics counters; sw_reset clears them without touching arbitration
  always_ff @(posedge pcie_clk) begin
    if (!pcie_reset_n || sw_reset) begin
      req_burst_cnt <= '0;
      req_beat_cnt  <= '0;
      bad_burst_cnt <= 32'd0;
    end else begin
      if (accept_s) begin
        req_beat_cnt[grant_s] <= req_beat_cnt[grant_s] + 32'd1;
      end
      if (burst_done_s) begin
        req_burst_cnt[grant_s] <= req_burst_cnt[grant_s] + 32'd1;
      end
      if (first_acc_s && bad_bc_s) begin
        bad_burst_cnt <= bad_burst_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_bas_write_arbiter.sv
// Table-driven bench for pcie_bas_write_arbiter: each row is one clock cycle of
// requester/PCIe inputs plus the expected grant and back-pressure in that cycle.
module tb_pcie_bas_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_reset;
  logic [1:0][31:0] burst_cnt;
  logic [1:0][31:0] beat_cnt;
  logic [31:0] bad_cnt;

  pcie_bas_write_arbiter_if #(.NB_REQ(2)) bus ();

  pcie_bas_write_arbiter #(.NB_REQ(2), .MAX_BURST(8)) dut (
    .pcie_clk      (clk),
    .pcie_reset_n  (rst_n),
    .sw_reset      (sw_reset),
    .bus           (bus),
    .req_burst_cnt (burst_cnt),
    .req_beat_cnt  (beat_cnt),
    .bad_burst_cnt (bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       sw;
    logic [1:0] wr;
    logic [3:0] bc0;
    logic [3:0] bc1;
    logic       bwait;
    logic       e_write;
    logic       e_own;
    logic [1:0] e_wreq;
  } vec_t;

  vec_t vq[$];
  int   next_idx = 0;
  int   checks   = 0;
  int   errors   = 0;

  logic [63:0]  addr_c [2];
  logic [511:0] data_c [2];
  logic [63:0]  be_c   [2];

  function automatic void add(input logic rstn, input logic sw, input logic [1:0] wr,
                              input logic [3:0] bc0, input logic [3:0] bc1, input logic bwait,
                              input logic e_write, input logic e_own, input logic [1:0] e_wreq);
    vec_t v;
    v.rstn = rstn; v.sw = sw; v.wr = wr; v.bc0 = bc0; v.bc1 = bc1; v.bwait = bwait;
    v.e_write = e_write; v.e_own = e_own; v.e_wreq = e_wreq;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst_n                    = 1'b1;
    sw_reset                 = 1'b0;
    bus.req_write            = 2'b00;
    bus.pcie_bas_waitrequest = 1'b0;
  endtask

  // Applies every row not yet applied, then lets one more edge settle counters
  task automatic run_pending();
    vec_t v;
    while (next_idx < vq.size()) begin
      v = vq[next_idx];
      @(negedge clk);
      rst_n                    = v.rstn;
      sw_reset                 = v.sw;
      bus.req_write            = v.wr;
      bus.req_burstcount[0]    = v.bc0;
      bus.req_burstcount[1]    = v.bc1;
      bus.pcie_bas_waitrequest = v.bwait;
      #1;
      chk($sformatf("vec%0d write", next_idx), 512'(bus.pcie_bas_write), 512'(v.e_write));
      chk($sformatf("vec%0d waitreq", next_idx), 512'(bus.req_waitrequest), 512'(v.e_wreq));
      if (v.e_write) begin
        chk($sformatf("vec%0d address", next_idx), 512'(bus.pcie_bas_address), 512'(addr_c[v.e_own]));
        chk($sformatf("vec%0d burstcount", next_idx), 512'(bus.pcie_bas_burstcount),
            512'(v.e_own ? v.bc1 : v.bc0));
        chk($sformatf("vec%0d writedata", next_idx), bus.pcie_bas_writedata, data_c[v.e_own]);
        chk($sformatf("vec%0d byteenable", next_idx), 512'(bus.pcie_bas_byteenable), 512'(be_c[v.e_own]));
      end
      next_idx++;
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] u0, input logic [31:0] u1, input logic [31:0] bad);
    chk({tag, " beat_cnt0"},  512'(beat_cnt[0]),  512'(b0));
    chk({tag, " beat_cnt1"},  512'(beat_cnt[1]),  512'(b1));
    chk({tag, " burst_cnt0"}, 512'(burst_cnt[0]), 512'(u0));
    chk({tag, " burst_cnt1"}, 512'(burst_cnt[1]), 512'(u1));
    chk({tag, " bad_cnt"},    512'(bad_cnt),      512'(bad));
  endtask

  initial begin
    addr_c[0] = 64'hA000_0000_0000_1000;
    addr_c[1] = 64'hB000_0000_0000_2000;
    data_c[0] = {16{32'hD00D_0A0A}};
    data_c[1] = {16{32'h1234_B1B1}};
    be_c[0]   = 64'hFFFF_FFFF_FFFF_FFFF;
    be_c[1]   = 64'h0F0F_0F0F_0F0F_0F0F;
    bus.req_address        = {addr_c[1], addr_c[0]};
    bus.req_writedata      = {data_c[1], data_c[0]};
    bus.req_byteenable     = {be_c[1], be_c[0]};
    bus.req_burstcount     = {4'd0, 4'd0};
    drive_idle();
    rst_n = 1'b0;

    // Reset state
    add(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11);
    add(1'b0, 1'b0, 2'b11, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 2'b11);
    run_pending();
    chk_cnt("reset", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Single requester, three back-to-back bursts of 4
    for (int i = 0; i < 12; i++) add(1'b1, 1'b0, 2'b01, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 2'b10);
    run_pending();
    chk_cnt("b2b", 32'd12, 32'd0, 32'd3, 32'd0, 32'd0);

    // Reset, then simultaneous contention of two bursts of 2
    add(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 2'b11, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 2'b10, 4'd2, 4'd2, 1'b0, 1'b1, 1'b1, 2'b01);
    add(1'b1, 1'b0, 2'b11, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b10, 4'd1, 4'd1, 1'b0, 1'b1, 1'b1, 2'b01);
    run_pending();
    chk_cnt("contend", 32'd3, 32'd3, 32'd2, 32'd2, 32'd0);

    // Stalled first beat from req1 with req0 arriving during the stall
    add(1'b1, 1'b0, 2'b10, 4'd1, 4'd3, 1'b1, 1'b1, 1'b1, 2'b11);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 2'b11, 4'd1, 4'd3, 1'b1, 1'b1, 1'b1, 2'b11);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 2'b11, 4'd1, 4'd3, 1'b0, 1'b1, 1'b1, 2'b01);
    add(1'b1, 1'b0, 2'b01, 4'd1, 4'd3, 1'b0, 1'b1, 1'b0, 2'b10);
    run_pending();
    chk_cnt("stall", 32'd4, 32'd6, 32'd3, 32'd3, 32'd0);

    // Two-cycle bubble inside a burst of 4 while req1 waits
    add(1'b1, 1'b0, 2'b01, 4'd4, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b11, 4'd4, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 2'b10, 4'd4, 4'd1, 1'b0, 1'b0, 1'b0, 2'b10);
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 2'b11, 4'd4, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b10, 4'd4, 4'd1, 1'b0, 1'b1, 1'b1, 2'b01);
    run_pending();
    chk_cnt("bubble", 32'd8, 32'd7, 32'd4, 32'd4, 32'd0);

    // Illegal burstcounts: 0 acts as 1 beat, 12 locks for 8 beats
    add(1'b1, 1'b0, 2'b01, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b01, 4'd12, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 7; i++) add(1'b1, 1'b0, 2'b11, 4'd12, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b11, 4'd12, 4'd1, 1'b0, 1'b1, 1'b1, 2'b01);
    run_pending();
    chk_cnt("illegal", 32'd17, 32'd8, 32'd6, 32'd5, 32'd2);

    // Hard reset during beat 3 of 8, with rr_ptr pointing at req1 beforehand
    add(1'b1, 1'b0, 2'b01, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b01, 4'd8, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b11, 4'd8, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b0, 1'b0, 2'b11, 4'd8, 4'd1, 1'b0, 1'b0, 1'b0, 2'b11);
    add(1'b1, 1'b0, 2'b11, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b10, 4'd1, 4'd1, 1'b0, 1'b1, 1'b1, 2'b01);
    run_pending();
    chk_cnt("hard_reset", 32'd1, 32'd1, 32'd1, 32'd1, 32'd0);

    // sw_reset on beat 2 of a burst of 3: counters clear, lock holds
    add(1'b1, 1'b0, 2'b01, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b1, 2'b11, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    add(1'b1, 1'b0, 2'b11, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0, 2'b10);
    run_pending();
    chk_cnt("sw_reset", 32'd1, 32'd0, 32'd1, 32'd0, 32'd0);

    // Round-robin pointer survives sw_reset: req1 wins the next tie
    add(1'b1, 1'b0, 2'b11, 4'd1, 4'd1, 1'b0, 1'b1, 1'b1, 2'b01);
    run_pending();
    chk_cnt("after_sw", 32'd1, 32'd1, 32'd1, 32'd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
